// File: rtl/sine_sample_gen.sv
// Sine duty-sample generator: steps a 64-phase period at a programmable rate and
// hands attenuated 8-bit samples to the PWM modulator over valid/ready.
module sine_sample_gen #(
    parameter int unsigned DIV_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic [1:0]           atten,
    output logic [7:0]           sample,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 period_start,
    output logic [5:0]           phase,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);
    localparam logic [5:0]           PHASE_ONE = 6'd1;
    localparam logic [7:0]           MIDSCALE  = 8'd128;

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [5:0]           phase_q, phase_d;
    logic [7:0]           sample_q, sample_d;
    logic                 valid_q, valid_d;
    logic                 pstart_q, pstart_d;
    logic                 overrun_q, overrun_d;

    logic                 step;
    logic                 accept;
    logic [4:0]           tbl_idx;
    logic [6:0]           amp;
    logic [7:0]           new_sample;

    function automatic logic [6:0] quarter_wave(input logic [4:0] idx);
        logic [6:0] v;
        case (idx)
            5'd0:    v = 7'd0;
            5'd1:    v = 7'd12;
            5'd2:    v = 7'd25;
            5'd3:    v = 7'd37;
            5'd4:    v = 7'd49;
            5'd5:    v = 7'd60;
            5'd6:    v = 7'd71;
            5'd7:    v = 7'd81;
            5'd8:    v = 7'd90;
            5'd9:    v = 7'd98;
            5'd10:   v = 7'd106;
            5'd11:   v = 7'd112;
            5'd12:   v = 7'd117;
            5'd13:   v = 7'd122;
            5'd14:   v = 7'd125;
            5'd15:   v = 7'd126;
            5'd16:   v = 7'd127;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

    // Odd quadrants walk the table backwards; the upper half-period mirrors below midscale.
    always_comb begin
        tbl_idx    = phase_q[4] ? (5'd16 - {1'b0, phase_q[3:0]}) : {1'b0, phase_q[3:0]};
        amp        = quarter_wave(tbl_idx) >> atten;
        new_sample = phase_q[5] ? (MIDSCALE - {1'b0, amp}) : (MIDSCALE + {1'b0, amp});
    end

    always_comb begin
        step   = enable && (cnt_q >= divider);
        accept = valid_q && sample_ready;

        cnt_d     = cnt_q;
        phase_d   = phase_q;
        sample_d  = sample_q;
        pstart_d  = pstart_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (step) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (step) begin
            sample_d = new_sample;
            pstart_d = (phase_q == 6'd0);
            phase_d  = phase_q + PHASE_ONE;
            valid_d  = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end

        // A fresh overrun event outranks a simultaneous clear.
        if (step && valid_q && !sample_ready) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            phase_q   <= '0;
            sample_q  <= MIDSCALE;
            valid_q   <= 1'b0;
            pstart_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            pstart_q  <= pstart_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign period_start = pstart_q;
    assign phase        = phase_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sine_sample_gen.sv
// Directed self-checking bench for sine_sample_gen.
module tb_sine_sample_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] divider = '0;
    logic [1:0]  atten = '0;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic        period_start;
    logic [5:0]  phase;
    logic        overrun;
    logic        clr_overrun = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    sine_sample_gen #(.DIV_WIDTH(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .divider      (divider),
        .atten        (atten),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .period_start (period_start),
        .phase        (phase),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    always #5 clk = ~clk;

    // Half-wave reference: rise over phases 0..16, fall over 16..32, then mirror below 128.
    function automatic logic [7:0] sine_ref(input int p, input int sh);
        int qtab [17] = '{0, 12, 25, 37, 49, 60, 71, 81, 90, 98, 106, 112, 117, 122, 125, 126, 127};
        int h;
        int a;
        h = p % 32;
        if (h > 16) h = 32 - h;
        a = qtab[h] >> sh;
        return (p < 32) ? 8'(128 + a) : 8'(128 - a);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [11:0] div, input logic [1:0] att, input logic rdy);
        rst = 1'b1;
        enable = 1'b1;
        divider = div;
        atten = att;
        sample_ready = rdy;
        clr_overrun = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        sample_ready = 1'b1;
        clr_overrun = 1'b0;
        divider = '0;
        cyc();
        cyc();
        n_vec++;
        if ({sample, sample_valid, period_start, phase, overrun} !== {8'd128, 1'b0, 1'b0, 6'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: sample=%0d valid=%0b pstart=%0b phase=%0d ovr=%0b, need 128/0/0/0/0",
                     sample, sample_valid, period_start, phase, overrun);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_samples();
        int n;
        logic [7:0] exp_s [4] = '{8'd128, 8'd140, 8'd153, 8'd165};
        do_reset(12'd3, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                cyc();
                n++;
            end while (!sample_valid && n < 20);
            n_vec++;
            if (n !== 4) begin
                n_err++;
                $display("FAIL first_latency[%0d]: valid after %0d edges, need 4", k, n);
            end
            n_vec++;
            if (sample !== exp_s[k] || period_start !== (k == 0) || phase !== 6'(k + 1)) begin
                n_err++;
                $display("FAIL first_sample[%0d]: sample=%0d pstart=%0b phase=%0d, need %0d/%0b/%0d",
                         k, sample, period_start, phase, exp_s[k], (k == 0), k + 1);
            end
        end
    endtask

    task automatic test_full_period();
        int p;
        do_reset(12'd0, 2'd0, 1'b1);
        for (int j = 1; j <= 65; j++) begin
            cyc();
            p = (j - 1) % 64;
            n_vec++;
            if (sample !== sine_ref(p, 0) || sample_valid !== 1'b1 || period_start !== (p == 0)
                || phase !== 6'(j % 64) || overrun !== 1'b0) begin
                n_err++;
                $display("FAIL full_period[p=%0d]: sample=%0d valid=%0b pstart=%0b phase=%0d ovr=%0b, need %0d/1/%0b/%0d/0",
                         p, sample, sample_valid, period_start, phase, overrun, sine_ref(p, 0), (p == 0), j % 64);
            end
            if (p == 16 || p == 32 || p == 48 || p == 63) begin
                n_vec++;
                if (sample !== ((p == 16) ? 8'd255 : (p == 32) ? 8'd128 : (p == 48) ? 8'd1 : 8'd116)) begin
                    n_err++;
                    $display("FAIL landmark[p=%0d]: sample=%0d", p, sample);
                end
            end
        end
    endtask

    task automatic test_atten();
        do_reset(12'd0, 2'd2, 1'b1);
        for (int j = 1; j <= 49; j++) begin
            cyc();
            if (j == 9 || j == 17 || j == 49) begin
                n_vec++;
                if (sample !== ((j == 9) ? 8'd150 : (j == 17) ? 8'd159 : 8'd97)) begin
                    n_err++;
                    $display("FAIL atten2[p=%0d]: sample=%0d, need %0d", j - 1, sample,
                             (j == 9) ? 150 : (j == 17) ? 159 : 97);
                end
            end
        end
    endtask

    task automatic test_overrun();
        do_reset(12'd1, 2'd0, 1'b0);
        cyc();
        cyc();
        n_vec++;
        if (sample_valid !== 1'b1 || sample !== 8'd128 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_first: valid=%0b sample=%0d ovr=%0b, need 1/128/0", sample_valid, sample, overrun);
        end
        cyc();
        n_vec++;
        if (sample_valid !== 1'b1 || sample !== 8'd128 || phase !== 6'd1) begin
            n_err++;
            $display("FAIL ovr_hold: valid=%0b sample=%0d phase=%0d, need 1/128/1", sample_valid, sample, phase);
        end
        cyc();
        n_vec++;
        if (sample !== 8'd140 || overrun !== 1'b1 || phase !== 6'd2 || sample_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_set: sample=%0d ovr=%0b phase=%0d valid=%0b, need 140/1/2/1",
                     sample, overrun, phase, sample_valid);
        end
        enable = 1'b0;
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;
        n_vec++;
        if (overrun !== 1'b0 || sample !== 8'd140 || sample_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_clear: ovr=%0b sample=%0d valid=%0b, need 0/140/1", overrun, sample, sample_valid);
        end
        atten = 2'd3;
        cyc();
        n_vec++;
        if (sample !== 8'd140) begin
            n_err++;
            $display("FAIL atten_no_recompute: sample=%0d, need 140", sample);
        end
        atten = 2'd0;
        enable = 1'b1;
        cyc();
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;
        n_vec++;
        if (overrun !== 1'b1 || sample !== 8'd153 || phase !== 6'd3) begin
            n_err++;
            $display("FAIL ovr_set_wins: ovr=%0b sample=%0d phase=%0d, need 1/153/3", overrun, sample, phase);
        end
        sample_ready = 1'b1;
        clr_overrun = 1'b1;
        cyc();
        clr_overrun = 1'b0;
        n_vec++;
        if (overrun !== 1'b0 || sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL accept_clear: ovr=%0b valid=%0b, need 0/0", overrun, sample_valid);
        end
    endtask

    task automatic test_midcount();
        do_reset(12'd20, 2'd0, 1'b0);
        repeat (10) cyc();
        n_vec++;
        if (phase !== 6'd0 || sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_before: phase=%0d valid=%0b, need 0/0", phase, sample_valid);
        end
        divider = 12'd5;
        cyc();
        n_vec++;
        if (phase !== 6'd1 || sample_valid !== 1'b1 || sample !== 8'd128) begin
            n_err++;
            $display("FAIL mid_step: phase=%0d valid=%0b sample=%0d, need 1/1/128", phase, sample_valid, sample);
        end
        cyc();
        cyc();
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            n_vec++;
            if (phase !== 6'd1 || sample_valid !== 1'b1 || sample !== 8'd128) begin
                n_err++;
                $display("FAIL frozen[%0d]: phase=%0d valid=%0b sample=%0d, need 1/1/128",
                         k, phase, sample_valid, sample);
            end
        end
        enable = 1'b1;
        cyc();
        cyc();
        cyc();
        n_vec++;
        if (phase !== 6'd1) begin
            n_err++;
            $display("FAIL resume_cnt_held: phase=%0d, need 1", phase);
        end
        cyc();
        n_vec++;
        if (phase !== 6'd2 || sample !== 8'd140 || overrun !== 1'b1) begin
            n_err++;
            $display("FAIL resume_step: phase=%0d sample=%0d ovr=%0b, need 2/140/1", phase, sample, overrun);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(12'd0, 2'd0, 1'b0);
        repeat (37) cyc();
        n_vec++;
        if (phase !== 6'd37 || sample_valid !== 1'b1 || overrun !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: phase=%0d valid=%0b ovr=%0b, need 37/1/1", phase, sample_valid, overrun);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_vec++;
        if ({sample, sample_valid, period_start, phase, overrun} !== {8'd128, 1'b0, 1'b0, 6'd0, 1'b0}) begin
            n_err++;
            $display("FAIL midstream_reset: sample=%0d valid=%0b pstart=%0b phase=%0d ovr=%0b, need 128/0/0/0/0",
                     sample, sample_valid, period_start, phase, overrun);
        end
        divider = 12'd2;
        cyc();
        cyc();
        n_vec++;
        if (sample_valid !== 1'b0 || phase !== 6'd0) begin
            n_err++;
            $display("FAIL post_reset_cnt: valid=%0b phase=%0d, need 0/0", sample_valid, phase);
        end
        cyc();
        n_vec++;
        if (sample_valid !== 1'b1 || phase !== 6'd1 || period_start !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_step: valid=%0b phase=%0d pstart=%0b, need 1/1/1",
                     sample_valid, phase, period_start);
        end
    endtask

    initial begin
        test_reset();
        test_first_samples();
        test_full_period();
        test_atten();
        test_overrun();
        test_midcount();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sine_sample_gen.md
Name: sine_sample_gen

Overview:
- Upstream stage of the PWM sine output path.
- Steps a 64-entry-per-period sine phase at a programmable rate and reconstructs each 8-bit duty sample from a 17-entry quarter-wave table with an attenuation shift.
- Presents each sample over a valid/ready handshake to the PWM modulator, which consumes one duty value per PWM period.
- Flags overrun when the modulator fails to take a sample before the next one is produced.

Parameters:
DIV_WIDTH, 12, width of the step-rate divider input and internal tick counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
enable  input  1  1 = tick counter and phase advance; 0 = both frozen
divider  input  DIV_WIDTH  step period minus one, in clk cycles
atten  input  2  amplitude attenuation; quarter-table value right-shifted by atten
sample  output  8  duty sample, unsigned, midscale 128
sample_valid  output  1  sample held and pending for consumer
sample_ready  input  1  consumer accepts sample when high with sample_valid
period_start  output  1  qualifies sample: 1 if sample came from phase 0
phase  output  6  current phase index (next phase to be emitted)
overrun  output  1  sticky: a sample was overwritten while unaccepted
clr_overrun  input  1  clears overrun

Behaviour:
- Reset values, applied at the first clk edge with rst=1: tick counter 0, phase 0, sample 8'h80, sample_valid 0, period_start 0, overrun 0. A pending sample is dropped. Reset takes priority over every other input.
- Tick counter:
  - Step condition in a cycle: enable=1 and cnt >= divider.
  - On step: cnt <= 0. Else if enable: cnt <= cnt+1. Else hold.
  - Step period is divider+1 cycles; divider=0 steps every cycle.
  - Lowering divider below cnt mid-count causes a step in the next enabled cycle.
- On step:
  - sample <= f(phase, atten); period_start <= (phase==0); phase <= phase+1, mod 64 (63 wraps to 0); sample_valid <= 1.
  - Latency: the sample is visible with valid in the cycle after the step condition.
- Quarter table Q[0..16] = 0,12,25,37,49,60,71,81,90,98,106,112,117,122,125,126,127.
- Sample function, with q = phase[5:4], i = phase[3:0], A(x) = Q[x] >> atten:
  - q=0: 128+A(i)
  - q=1: 128+A(16-i)
  - q=2: 128-A(i)
  - q=3: 128-A(16-i)
  - Results are 8-bit, never wrap; range 1..255 at atten=0.
- Handshake:
  - Acceptance occurs when sample_valid=1 and sample_ready=1 in the same cycle.
  - Acceptance without a step: sample_valid <= 0.
  - Acceptance and step in the same cycle: new sample loaded, sample_valid stays 1, no overrun.
  - Step while valid=1 and ready=0: new sample overwrites (latest wins), overrun <= 1, phase advances normally.
  - sample, period_start stable while valid=1 and no step.
- enable=0: counter and phase frozen; a pending sample remains valid until accepted.
- Overrun:
  - clr_overrun=1 clears overrun.
  - Simultaneous clr_overrun and a new overrun event: overrun stays 1 (set wins).
- atten change affects only samples produced after the change; a held sample is not recomputed.
- No combinational path from sample_ready to any output; all outputs registered.

Test Plan:
- Reset then divider=3, enable=1, ready=1 → first valid at cycle 5 after reset release with sample=128, period_start=1; subsequent valids every 4 cycles: 140,153,165 (phases 1..3).
- divider=0, atten=0, ready=1, 64 steps → sequence includes phase16=255, phase32=128, phase48=1, phase63=116; period_start high only on phase-0 samples; phase wraps 63→0.
- atten=2, divider=0 → phase16 sample=159, phase48=97, phase8=150.
- ready=0, divider=1 → valid holds first sample; second step sets overrun=1 and sample updates to next phase; clr_overrun=1 with no further step clears it; clr and overrun event together keep overrun=1.
- Mid-count: cnt=10 with divider=20, set divider=5 → step next cycle; enable=0 for 7 cycles → phase and cnt unchanged, pending sample stays valid.
- Assert rst while valid=1 and phase=37 → next cycle sample=128, valid=0, phase=0, overrun=0, cnt=0.
